// File: rtl/rr_arb_mux.sv
// rr_arb_mux: N-channel arbiting mux into a one-entry valid/ready output register.
// Round-robin (RR=1) or fixed lowest-index priority (RR=0).
module rr_arb_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter bit RR    = 1,
    localparam int SELW = (N <= 2) ? 1 : (N <= 4) ? 2 : 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_sel,
    input  logic               out_ready
);
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_sel_q, ptr_q, ptr_d, gidx, j;
    logic [N-1:0]     grant;
    logic             load, xfer;

    // Scan backwards from ptr+N-1 to ptr so the last hit is the first in rotation order.
    // With RR=0 the pointer stays at 0, giving lowest-index priority.
    always_comb begin
        grant = '0;
        gidx  = '0;
        j     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = SELW'((int'(ptr_q) + k) % N);
            if (in_valid[j]) begin
                grant    = '0;
                grant[j] = 1'b1;
                gidx     = j;
            end
        end
    end

    assign load       = ~out_valid_q | out_ready;
    assign in_ready   = (reset_n && load) ? grant : '0;
    assign xfer       = |in_ready;
    assign out_data_d = in_data[gidx*WIDTH +: WIDTH];
    assign ptr_d      = RR ? ((gidx == SELW'(N - 1)) ? '0 : gidx + 1'b1) : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_sel_q   <= gidx;
            ptr_q       <= ptr_d;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_arb_mux.sv
// tb_rr_arb_mux: directed checks of a round-robin and a fixed-priority instance sharing stimulus.
module tb_rr_arb_mux;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   in_valid;
    logic [127:0] in_data;
    logic         out_ready;
    logic [3:0]   rr_in_ready, fp_in_ready;
    logic         rr_out_valid, fp_out_valid;
    logic [31:0]  rr_out_data, fp_out_data;
    logic [1:0]   rr_out_sel, fp_out_sel;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 clk = ~clk;

    rr_arb_mux #(.WIDTH(32), .N(4), .RR(1)) u_rr (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_sel(rr_out_sel), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(32), .N(4), .RR(0)) u_fp (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_sel(fp_out_sel), .out_ready(out_ready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        in_data   = {32'hC0C0_0003, 32'hC0C0_0002, 32'hC0C0_0001, 32'hC0C0_0000};
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        #1;
        chk("t1_in_ready_async", 32'(rr_in_ready), 32'h0);
        tick();
        tick();
        chk("t1_out_valid", 32'(rr_out_valid), 32'h0);
        chk("t1_out_data", rr_out_data, 32'h0);
        chk("t1_out_sel", 32'(rr_out_sel), 32'h0);
        chk("t1_in_ready", 32'(rr_in_ready), 32'h0);
        chk("t1_fp_in_ready", 32'(fp_in_ready), 32'h0);

        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("t2_in_ready", 32'(rr_in_ready), 32'(4'b0001 << (k % 4)));
            tick();
            chk("t2_out_valid", 32'(rr_out_valid), 32'h1);
            chk("t2_out_sel", 32'(rr_out_sel), 32'(k % 4));
            chk("t2_out_data", rr_out_data, 32'hC0C0_0000 + 32'(k % 4));
        end

        in_valid = 4'b0001;
        tick();
        chk("t3_pre_sel", 32'(rr_out_sel), 32'h0);
        in_valid = 4'b1001;
        #1;
        chk("t3_ready_a", 32'(rr_in_ready), 32'b1000);
        tick();
        chk("t3_sel_a", 32'(rr_out_sel), 32'h3);
        chk("t3_ready_b", 32'(rr_in_ready), 32'b0001);
        tick();
        chk("t3_sel_b", 32'(rr_out_sel), 32'h0);
        chk("t3_ready_c", 32'(rr_in_ready), 32'b1000);
        tick();
        chk("t3_sel_c", 32'(rr_out_sel), 32'h3);

        in_data[63:32] = 32'hDEAD_BEEF;
        in_valid = 4'b0010;
        tick();
        chk("t4_load_data", rr_out_data, 32'hDEAD_BEEF);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_in_ready", 32'(rr_in_ready), 32'h0);
            tick();
            chk("t4_out_valid", 32'(rr_out_valid), 32'h1);
            chk("t4_out_data", rr_out_data, 32'hDEAD_BEEF);
            chk("t4_out_sel", 32'(rr_out_sel), 32'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("t4_ptr_held", 32'(rr_in_ready), 32'b0100);
        tick();
        chk("t4_sel_after", 32'(rr_out_sel), 32'h2);

        in_valid = 4'b0110;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("t5_fp_in_ready", 32'(fp_in_ready), 32'b0010);
            tick();
            chk("t5_fp_sel", 32'(fp_out_sel), 32'h1);
        end
        in_valid = 4'b0100;
        tick();
        chk("t5_fp_sel_drop", 32'(fp_out_sel), 32'h2);

        tick();
        chk("t6_pending_sel", 32'(rr_out_sel), 32'h2);
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        reset_n   = 1'b0;
        #1;
        chk("t6_rst_in_ready", 32'(rr_in_ready), 32'h0);
        tick();
        chk("t6_rst_out_valid", 32'(rr_out_valid), 32'h0);
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t6_first_grant", 32'(rr_in_ready), 32'b0001);
        tick();
        chk("t6_first_sel", 32'(rr_out_sel), 32'h0);
        chk("t6_first_data", rr_out_data, 32'hC0C0_0000);

        in_valid = 4'b0000;
        #1;
        chk("drain_in_ready", 32'(rr_in_ready), 32'h0);
        tick();
        chk("drain_out_valid", 32'(rr_out_valid), 32'h0);
        chk("drain_data_hold", rr_out_data, 32'hC0C0_0000);
        chk("drain_sel_hold", 32'(rr_out_sel), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
